// File: rtl/color_pkg.sv
// Shared types and constants for the two-requester color arbiter.
package color_pkg;

    // Transaction FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    // A color is a 2-bit code
    typedef logic [1:0] color_t;

    // Codes that may not directly follow each other in the accepted history
    localparam color_t RULE_C00 = 2'b00;
    localparam color_t RULE_C01 = 2'b01;

endpackage

// File: rtl/color_rule.sv
// Combinational acceptance rules for a proposed color against the
// accepted-color history.
//   Rule A: reject a third identical color in a row.
//   Rule B: reject 00 directly after 01 and 01 directly after 00.
module color_rule
    import color_pkg::*;
(
    input  logic [3:0] hist,
    input  logic [1:0] cnt,
    input  color_t     color,
    output logic       ok
);

    logic w_rule_a;
    logic w_rule_b;

    assign w_rule_a = (cnt >= 2'd2) && (color == hist[3:2]) && (color == hist[1:0]);

    assign w_rule_b = (cnt != 2'd0) &&
                      (((hist[1:0] == RULE_C00) && (color == RULE_C01)) ||
                       ((hist[1:0] == RULE_C01) && (color == RULE_C00)));

    assign ok = !(w_rule_a || w_rule_b);

endmodule

// File: rtl/color_arbiter.sv
// Two-requester color arbiter. A granted requester's color is checked
// against the history of accepted colors; the result is returned with a
// one-cycle ack pulse two edges after the grant.
//
// Build option: COLOR_ARB_RR_EN selects round-robin arbitration with a
// 1-bit preference pointer; otherwise requester 0 always wins ties.
//
// state | meaning
// IDLE  | waiting for a request; grant the winner and latch its color
// CHECK | evaluate rules, update history / counters
// RESP  | issue ack + ok, drop grant, return to IDLE
module color_arbiter
    import color_pkg::*;
#(
    parameter int REJ_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  color_t           color0,
    input  color_t           color1,
    output logic [1:0]       gnt,
    output logic             ack,
    output logic             ok,
    output logic [3:0]       hist,
    output logic [1:0]       cnt,
    output logic [REJ_W-1:0] rej_cnt
);

    state_t           r_state;
    logic [1:0]       r_gnt;
    logic             r_ack;
    logic             r_ok;
    logic [3:0]       r_hist;
    logic [1:0]       r_cnt;
    logic [REJ_W-1:0] r_rej;
    color_t           r_color;
    logic             r_pass;

    state_t           w_state_nxt;
    logic [1:0]       w_gnt_nxt;
    logic             w_ack_nxt;
    logic             w_ok_nxt;
    logic [3:0]       w_hist_nxt;
    logic [1:0]       w_cnt_nxt;
    logic [REJ_W-1:0] w_rej_nxt;
    color_t           w_color_nxt;
    logic             w_pass_nxt;

    logic             w_win;
    logic             w_rule_ok;

`ifdef COLOR_ARB_RR_EN
    logic r_ptr;
    logic w_grant;

    // Pointer names the preferred requester on a tie
    assign w_win   = (req == 2'b11) ? r_ptr : req[1];
    assign w_grant = (r_state == IDLE) && (req != 2'b00);

    // After every grant, prefer the requester that did not just win
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_grant) begin
            r_ptr <= ~w_win;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it is requesting
    assign w_win = ~req[0];
`endif

    color_rule u_rule (
        .hist  (r_hist),
        .cnt   (r_cnt),
        .color (r_color),
        .ok    (w_rule_ok)
    );

    // Next-state and next-register values
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = 1'b0;
        w_ok_nxt    = 1'b0;
        w_hist_nxt  = r_hist;
        w_cnt_nxt   = r_cnt;
        w_rej_nxt   = r_rej;
        w_color_nxt = r_color;
        w_pass_nxt  = r_pass;
        case (r_state)
            IDLE: begin
                if (req != 2'b00) begin
                    w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
                    w_color_nxt = w_win ? color1 : color0;
                    w_state_nxt = CHECK;
                end else begin
                    w_gnt_nxt = 2'b00;
                end
            end
            CHECK: begin
                w_pass_nxt = w_rule_ok;
                if (w_rule_ok) begin
                    w_hist_nxt = {r_hist[1:0], r_color};
                    w_cnt_nxt  = (r_cnt == 2'd3) ? r_cnt : r_cnt + 2'd1;
                end else begin
                    w_rej_nxt = (&r_rej) ? r_rej : r_rej + REJ_W'(1);
                end
                w_state_nxt = RESP;
            end
            RESP: begin
                w_ack_nxt   = 1'b1;
                w_ok_nxt    = r_pass;
                w_gnt_nxt   = 2'b00;
                w_state_nxt = IDLE;
            end
            default: begin
                w_gnt_nxt   = 2'b00;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_ack   <= 1'b0;
            r_ok    <= 1'b0;
            r_hist  <= 4'b0000;
            r_cnt   <= 2'd0;
            r_rej   <= '0;
            r_color <= 2'b00;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_ok    <= w_ok_nxt;
            r_hist  <= w_hist_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rej   <= w_rej_nxt;
            r_color <= w_color_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign ack     = r_ack;
    assign ok      = r_ok;
    assign hist    = r_hist;
    assign cnt     = r_cnt;
    assign rej_cnt = r_rej;

endmodule

// File: tb/tb_color_arbiter.sv
// Bench for color_arbiter: transaction-level reference model, per-cycle
// comparison, directed scenarios with literal expectations, then random traffic.
module tb_color_arbiter;

    localparam int REJ_W   = 2;
    localparam int REJ_MAX = (1 << REJ_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req;
    logic [1:0]       color0;
    logic [1:0]       color1;
    logic [1:0]       gnt;
    logic             ack;
    logic             ok;
    logic [3:0]       hist;
    logic [1:0]       cnt;
    logic [REJ_W-1:0] rej_cnt;

    color_arbiter #(.REJ_W(REJ_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .color0  (color0),
        .color1  (color1),
        .gnt     (gnt),
        .ack     (ack),
        .ok      (ok),
        .hist    (hist),
        .cnt     (cnt),
        .rej_cnt (rej_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Accepted colors are kept as a plain list; history and count are derived
    // from it. A transaction runs three edges: grant, decide, respond.
    int         acc[$];
    int         rejs;
    int         phase;
    bit         ptr;
    bit         m_pass;
    int         m_col;
    int         m_w;
    logic [1:0] e_gnt;
    bit         e_ack;
    bit         e_ok;

    function automatic bit rule_ok(input int c);
        int n = acc.size();
        if (n >= 2 && acc[n-1] == c && acc[n-2] == c) return 1'b0;
        if (n >= 1 && ((acc[n-1] == 0 && c == 1) || (acc[n-1] == 1 && c == 0))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_hist();
        int n = acc.size();
        int h_new = (n >= 1) ? acc[n-1] : 0;
        int h_old = (n >= 2) ? acc[n-2] : 0;
        return 4'(h_old * 4 + h_new);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc.delete();
            rejs  = 0;
            phase = 0;
            ptr   = 1'b0;
            e_gnt = 2'b00;
            e_ack = 1'b0;
            e_ok  = 1'b0;
        end else begin
            e_ack = 1'b0;
            e_ok  = 1'b0;
            if (phase == 2) begin
                e_ack = 1'b1;
                e_ok  = m_pass;
                e_gnt = 2'b00;
                phase = 0;
            end else if (phase == 1) begin
                m_pass = rule_ok(m_col);
                if (m_pass) acc.push_back(m_col);
                else        rejs++;
                phase = 2;
            end else if (req != 2'b00) begin
`ifdef COLOR_ARB_RR_EN
                if (req == 2'b11) m_w = int'(ptr);
                else              m_w = req[1] ? 1 : 0;
                ptr = (m_w == 0);
`else
                m_w = req[0] ? 0 : 1;
`endif
                e_gnt = (m_w == 1) ? 2'b10 : 2'b01;
                m_col = (m_w == 1) ? int'(color1) : int'(color0);
                phase = 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt", gnt, e_gnt);
            check("ack", ack, e_ack);
            if (e_ack) check("ok", ok, e_ok);
            check("hist", hist, exp_hist());
            check("cnt", cnt, (acc.size() > 3) ? 3 : acc.size());
            check("rej_cnt", rej_cnt, (rejs > REJ_MAX) ? REJ_MAX : rejs);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the ack cycle
    task automatic run_txn(input logic [1:0] r, input logic [1:0] c0, input logic [1:0] c1,
                           output logic [1:0] g, output logic o);
        req    = r;
        color0 = c0;
        color1 = c1;
        @(posedge clk); #1;
        g   = gnt;
        req = 2'b00;
        @(posedge clk); #1;
        check("ack_not_early", ack, 1'b0);
        @(posedge clk); #1;
        check("ack_pulse", ack, 1'b1);
        o = ok;
    endtask

    logic [1:0] g;
    logic       o;
    logic [1:0] exp_seq [4];
    logic [1:0] prev;
    int         got;

    initial begin
        rst_n  = 1'b1;
        req    = 2'b00;
        color0 = 2'b00;
        color1 = 2'b00;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_gnt", gnt, 2'b00);
        check("rst_hist", hist, 4'b0000);
        do_reset();

        // Single accept after reset
        run_txn(2'b01, 2'b10, 2'b00, g, o);
        check("first_gnt", g, 2'b01);
        check("first_ok", o, 1'b1);
        check("first_hist", hist, 4'b0010);
        check("first_cnt", cnt, 2'd1);

        // Three identical colors: third rejected by rule A
        do_reset();
        run_txn(2'b01, 2'b11, 2'b00, g, o); check("same1_ok", o, 1'b1);
        run_txn(2'b01, 2'b11, 2'b00, g, o); check("same2_ok", o, 1'b1);
        run_txn(2'b01, 2'b11, 2'b00, g, o); check("same3_ok", o, 1'b0);
        check("same_hist", hist, 4'b1111);
        check("same_cnt", cnt, 2'd2);
        check("same_rej", rej_cnt, 2'd1);

        // 00 then 01: rejected by rule B (requester 1 used this time)
        do_reset();
        run_txn(2'b10, 2'b00, 2'b00, g, o);
        check("b_gnt", g, 2'b10);
        check("b_first_ok", o, 1'b1);
        run_txn(2'b10, 2'b00, 2'b01, g, o);
        check("b_ok", o, 1'b0);
        check("b_rej", rej_cnt, 2'd1);
        check("b_hist_low", hist[1:0], 2'b00);

        // Both requesters held high over four transactions
        do_reset();
`ifdef COLOR_ARB_RR_EN
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
`else
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
`endif
        color0 = 2'b10;
        color1 = 2'b11;
        req    = 2'b11;
        got    = 0;
        prev   = 2'b00;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            @(posedge clk); #1;
            if (gnt != 2'b00 && prev == 2'b00) begin
                check("arb_seq", gnt, exp_seq[got]);
                got++;
            end
            prev = gnt;
        end
        check("arb_count", got, 4);
        req = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Reset during CHECK aborts the transaction
        do_reset();
        run_txn(2'b01, 2'b10, 2'b00, g, o);
        req    = 2'b01;
        color0 = 2'b11;
        @(posedge clk); #1;
        check("abort_gnt_before", gnt, 2'b01);
        req   = 2'b00;
        rst_n = 1'b0;
        #1;
        check("abort_gnt", gnt, 2'b00);
        check("abort_ack", ack, 1'b0);
        check("abort_ok", ok, 1'b0);
        check("abort_hist", hist, 4'b0000);
        check("abort_cnt", cnt, 2'd0);
        check("abort_rej", rej_cnt, 2'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_no_ack", ack, 1'b0);
        end
        run_txn(2'b01, 2'b01, 2'b00, g, o);
        check("after_abort_gnt", g, 2'b01);
        check("after_abort_ok", o, 1'b1);
        check("after_abort_hist", hist, 4'b0001);

        // Rejection counter saturation (REJ_W=2)
        do_reset();
        run_txn(2'b01, 2'b00, 2'b00, g, o);
        repeat (5) run_txn(2'b01, 2'b01, 2'b00, g, o);
        check("rej_sat", rej_cnt, 2'd3);
        check("rej_sat_cnt", cnt, 2'd1);

        // Accept counter saturation
        do_reset();
        run_txn(2'b01, 2'b10, 2'b00, g, o);
        run_txn(2'b01, 2'b11, 2'b00, g, o);
        run_txn(2'b01, 2'b10, 2'b00, g, o);
        run_txn(2'b01, 2'b11, 2'b00, g, o);
        check("cnt_sat", cnt, 2'd3);
        check("cnt_sat_hist", hist, 4'b1011);

        // Random traffic; colors only change while their request is low
        do_reset();
        repeat (3000) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            if (!req[0]) color0 = 2'($urandom_range(0, 3));
            if (!req[1]) color1 = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                end else begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b1;
                end
            end
        end
        req = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/color_arbiter.md
COLOR_ARBITER -- requirements
Module: color_arbiter

Interface
REQ-001 Parameter REJ_W, default 4: width of the rejection counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  2  per-requester request; bit i belongs to requester i.
REQ-005 color0, color1  input  2 each  proposed color of requester 0 and requester 1; held stable while the matching req bit is high.
REQ-006 gnt  output  2  registered one-hot grant; at most one bit set.
REQ-007 ack  output  1  one-cycle pulse ending a transaction.
REQ-008 ok  output  1  valid only while ack=1; 1 means accepted, 0 means rejected.
REQ-009 hist  output  4  last two accepted colors; [3:2] older, [1:0] newer.
REQ-010 cnt  output  2  number of accepted colors, saturating at 3.
REQ-011 rej_cnt  output  REJ_W  number of rejections, saturating at all-ones.

Function
REQ-012 The FSM SHALL have three states: IDLE, CHECK and RESP.
REQ-013 In IDLE with req!=0, the FSM SHALL select a winner, set gnt, latch the winner's color and go to CHECK. In IDLE with req=0, it SHALL stay in IDLE with gnt=0.
REQ-014 In CHECK, the FSM SHALL evaluate the rules against the latched color, update the history and counters, and go to RESP.
REQ-015 In RESP, the FSM SHALL assert ack for exactly one cycle, drive ok, clear gnt on the next edge and return to IDLE.
REQ-016 Latency: with req sampled at edge N, gnt SHALL be visible after N, ack after N+2, and the next grant no earlier than after N+3.
REQ-017 Rule A: a color SHALL be rejected when cnt>=2 and the color equals both hist[3:2] and hist[1:0].
REQ-018 Rule B: a color SHALL be rejected when cnt>=1 and {hist[1:0], color} is {00,01} or {01,00}.
REQ-019 On accept, the block SHALL set hist <= {hist[1:0], color} and cnt <= min(cnt+1, 3); rej_cnt SHALL not change.
REQ-020 On reject, hist and cnt SHALL hold and rej_cnt SHALL increment, saturating.
REQ-021 A requester that drops req while granted SHALL not abort the transaction; it still completes and gets ack.
REQ-022 When both requesters request in the same IDLE cycle, the winner SHALL be chosen by the arbitration policy in REQ-026/REQ-027.
REQ-023 A non-granted request SHALL wait; it is not dropped.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, gnt=0, ack=0, ok=0, hist=0, cnt=0, rej_cnt=0 and clear the round-robin pointer to favour requester 0. This applies immediately, including mid-transaction.
REQ-025 A transaction interrupted by reset SHALL not produce ack; its requester must re-request.

Configuration
REQ-026 With COLOR_ARB_RR_EN defined, arbitration SHALL be round-robin: a 1-bit pointer names the preferred requester, and after each grant the pointer moves to the other requester.
REQ-027 Without COLOR_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 highest, and no pointer flop SHALL exist.

Structure
REQ-028 Package color_pkg SHALL hold the state enum (IDLE/CHECK/RESP), the 2-bit color typedef and the rule constants 00/01.
REQ-029 The rule evaluation SHALL be a combinational sub-module, color_rule, with inputs hist, cnt and color and output ok. color_arbiter instantiates it once.

Verification
REQ-030 Reset, then req=01, color0=10 → gnt=01 after edge 1, ack=1 and ok=1 after edge 3, hist=0010, cnt=1.
REQ-031 Accept 11 three times in a row → first two ok=1; third ok=0, hist=1111, cnt=2, rej_cnt=1.
REQ-032 Accept 00, then propose 01 → ok=0, rej_cnt increments, hist[1:0] stays 00.
REQ-033 Both requesters held high for 4 transactions → RR build: gnt sequence 01,10,01,10; non-RR build: 01,01,01,01.
REQ-034 rst_n pulsed low during CHECK → gnt=0, no ack, all outputs 0; the next request is served normally.
REQ-035 REJ_W=2 with 5 rejections → rej_cnt saturates at 3; cnt saturation checked with 4 accepts → cnt=3.
